// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the LC-3b pipeline control unit: FSM states, stage indices
// and the arbitration verdict that selects how the latches move each cycle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pipe_state_t;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic [2:0] {
        ARB_NONE   = 3'd0,
        ARB_FLUSH  = 3'd1,
        ARB_DSTALL = 3'd2,
        ARB_LUSE   = 3'd3,
        ARB_ISTALL = 3'd4,
        ARB_GO     = 3'd5
    } arb_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use interlock compare: a load in EX whose destination is read by the
// instruction in ID.
module pipe_hazard_detect #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  id_valid,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  luse
);

    logic src_hit;

    assign src_hit = (id_use_src1 && (id_src1 == ex_dest)) ||
                     (id_use_src2 && (id_src2 == ex_dest));
    assign luse    = id_valid & ex_valid & ex_is_load & src_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the LC-3b datapath: per-latch load enables and valid
// bits, wait handshakes, load-use interlock, branch flush and halt/drain.
// Performance counters are built only when PIPE_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = STG_WB + 1,
    parameter int REG_ADDR_W = 3,
    parameter int MEM_STAGE  = STG_MEM,
    parameter int BR_STAGE   = STG_WB
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_use_src2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  br_taken,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  load_pc,
    output logic [NUM_STAGES-2:0] load_latch,
    output logic [NUM_STAGES-2:0] valid,
    output logic                  flush,
    output logic                  halted,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt,
    output logic [31:0]           retire_cnt
);

    localparam int NL = NUM_STAGES - 1;

    if (BR_STAGE < MEM_STAGE) begin : g_bad_br_stage
        $error("pipe_ctrl: BR_STAGE must be >= MEM_STAGE");
    end
    if (NL < 2 || MEM_STAGE < 1 || BR_STAGE > NL) begin : g_bad_depth
        $error("pipe_ctrl: stage indices out of range for NUM_STAGES");
    end

    pipe_state_t   state_q, state_d;
    logic [NL-1:0] valid_q, valid_d;
    logic [NL-1:0] vin;
    logic          active, v_br, dstall, luse, istall;
    arb_t          arb;

    pipe_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_valid    (valid_q[STG_ID-1]),
        .ex_valid    (valid_q[STG_EX-1]),
        .ex_is_load  (ex_is_load),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use_src1 (id_use_src1),
        .id_use_src2 (id_use_src2),
        .ex_dest     (ex_dest),
        .luse        (luse)
    );

    assign active = (state_q == RUN) || (state_q == DRAIN);
    assign v_br   = valid_q[BR_STAGE-1] & br_taken;
    assign dstall = valid_q[MEM_STAGE-1] & dmem_req & ~dmem_resp;
    assign istall = ~imem_resp;

    always_comb begin
        arb = ARB_NONE;
        if (active) begin
            if (v_br)        arb = ARB_FLUSH;
            else if (dstall) arb = ARB_DSTALL;
            else if (luse)   arb = ARB_LUSE;
            else if (istall) arb = ARB_ISTALL;
            else             arb = ARB_GO;
        end
    end

    // vin is what each latch takes on load; default is a shift of the older
    // latch, with latch 0 fed a bubble unless a real fetch completes.
    always_comb begin
        load_pc    = 1'b0;
        load_latch = '0;
        flush      = 1'b0;
        vin        = {valid_q[NL-2:0], 1'b0};
        case (arb)
            ARB_FLUSH: begin
                load_pc    = 1'b1;
                flush      = 1'b1;
                load_latch = '1;
                for (int k = 0; k < NL; k++)
                    if (k < BR_STAGE) vin[k] = 1'b0;
            end
            ARB_DSTALL: begin
                for (int k = 0; k < NL; k++) begin
                    load_latch[k] = (k >= MEM_STAGE);
                    if (k == MEM_STAGE) vin[k] = 1'b0;
                end
            end
            ARB_LUSE: begin
                load_latch         = '1;
                load_latch[STG_IF] = 1'b0;
                vin[STG_ID]        = 1'b0;
            end
            ARB_ISTALL: begin
                load_latch = '1;
            end
            ARB_GO: begin
                load_latch  = '1;
                load_pc     = (state_q == RUN);
                vin[STG_IF] = (state_q == RUN);
            end
            default: ;
        endcase
        for (int k = 0; k < NL; k++)
            valid_d[k] = load_latch[k] ? vin[k] : valid_q[k];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = RUN;
            RUN:     if (halt_req) state_d = DRAIN;
            DRAIN:   if (valid_q == '0) state_d = HALTED;
            HALTED:  if (resume) state_d = RUN;
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign valid  = valid_q;
    assign halted = (state_q == HALTED);

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;
    logic        stall_win, retire;

    assign stall_win = (arb == ARB_DSTALL) || (arb == ARB_LUSE) || (arb == ARB_ISTALL);
    // The WB-feeding latch leaving (not held) is what retires its instruction.
    assign retire    = valid_q[NL-1] & load_latch[NL-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (stall_win) stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (flush)     flush_cnt_q  <= flush_cnt_q + 32'd1;
            if (retire)    retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign retire_cnt = retire_cnt_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a
// cycle-level model of the default 5-stage pipeline.
module tb_pipe_ctrl;

`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst_n;
    logic        imem_resp, dmem_req, dmem_resp;
    logic [2:0]  id_src1, id_src2, ex_dest;
    logic        id_use_src1, id_use_src2, ex_is_load;
    logic        br_taken, halt_req, resume;
    logic        load_pc, flush, halted;
    logic [3:0]  load_latch, valid;
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model: mode 0 reset, 1 run, 2 drain, 3 halted; mv = latch valid bits
    int          mode;
    logic [3:0]  mv, nv;
    int          nmode;
    logic [31:0] m_stall, m_flush, m_retire;
    logic        e_pc, e_fl, inc_s, inc_f, inc_r;
    logic [3:0]  e_ll;
    logic [3:0]  fill_exp [4];
    logic [31:0] s0;

    pipe_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_resp   (imem_resp),
        .dmem_req    (dmem_req),
        .dmem_resp   (dmem_resp),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use_src1 (id_use_src1),
        .id_use_src2 (id_use_src2),
        .ex_is_load  (ex_is_load),
        .ex_dest     (ex_dest),
        .br_taken    (br_taken),
        .halt_req    (halt_req),
        .resume      (resume),
        .load_pc     (load_pc),
        .load_latch  (load_latch),
        .valid       (valid),
        .flush       (flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task model_reset();
        mode = 0; mv = 4'b0000;
        m_stall = 0; m_flush = 0; m_retire = 0;
    endtask

    task model_eval();
        int verdict;
        logic hz;
        e_pc = 0; e_ll = 4'b0000; e_fl = 0; nv = mv;
        inc_s = 0; inc_f = 0; inc_r = 0; verdict = 0;
        hz = ex_is_load && ((id_use_src1 && id_src1 == ex_dest) ||
                            (id_use_src2 && id_src2 == ex_dest));
        if (mode == 1 || mode == 2) begin
            if (mv[3] && br_taken)                     verdict = 1;
            else if (mv[2] && dmem_req && !dmem_resp)  verdict = 2;
            else if (mv[1] && mv[0] && hz)             verdict = 3;
            else if (!imem_resp)                       verdict = 4;
            else                                       verdict = 5;
            inc_r = mv[3];
        end
        case (verdict)
            1: begin e_pc = 1; e_fl = 1; e_ll = 4'b1111; nv = 4'b0000; inc_f = 1; end
            2: begin e_ll = 4'b1000; nv = {1'b0, mv[2:0]}; inc_s = 1; end
            3: begin e_ll = 4'b1110; nv = {mv[2], mv[1], 1'b0, mv[0]}; inc_s = 1; end
            4: begin e_ll = 4'b1111; nv = {mv[2:0], 1'b0}; inc_s = 1; end
            5: begin e_ll = 4'b1111; e_pc = (mode == 1); nv = {mv[2:0], (mode == 1)}; end
            default: ;
        endcase
        case (mode)
            0: nmode = 1;
            1: nmode = halt_req ? 2 : 1;
            2: nmode = (mv == 4'b0000) ? 3 : 2;
            default: nmode = resume ? 1 : 3;
        endcase
    endtask

    task chk_cycle();
        logic [95:0] ecnt;
        @(negedge clk);
        model_eval();
        ecnt = PERF ? {m_stall, m_flush, m_retire} : 96'd0;
        checks++;
        if ({load_pc, load_latch, flush} !== {e_pc, e_ll, e_fl}) begin
            errors++;
            $display("FAIL ctrl cyc=%0d got pc=%b ll=%b fl=%b want pc=%b ll=%b fl=%b",
                     cyc, load_pc, load_latch, flush, e_pc, e_ll, e_fl);
        end
        checks++;
        if (valid !== mv) begin
            errors++;
            $display("FAIL valid cyc=%0d got %b want %b", cyc, valid, mv);
        end
        checks++;
        if (halted !== (mode == 3)) begin
            errors++;
            $display("FAIL halted cyc=%0d got %b want %b", cyc, halted, (mode == 3));
        end
        checks++;
        if ({stall_cnt, flush_cnt, retire_cnt} !== ecnt) begin
            errors++;
            $display("FAIL counters cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d", cyc,
                     stall_cnt, flush_cnt, retire_cnt, ecnt[95:64], ecnt[63:32], ecnt[31:0]);
        end
    endtask

    task adv();
        @(posedge clk);
        mv = nv; mode = nmode;
        if (inc_s) m_stall++;
        if (inc_f) m_flush++;
        if (inc_r) m_retire++;
        cyc++;
        #1;
    endtask

    task step();
        chk_cycle();
        adv();
    endtask

    task idle_in();
        imem_resp = 1; dmem_req = 0; dmem_resp = 0;
        id_src1 = 0; id_src2 = 0; ex_dest = 0;
        id_use_src1 = 0; id_use_src2 = 0; ex_is_load = 0;
        br_taken = 0; halt_req = 0; resume = 0;
    endtask

    task refill();
        repeat (4) step();
    endtask

    task test_reset();
        rst_n = 0;
        idle_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({load_pc, load_latch, flush, halted, valid} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got pc=%b ll=%b fl=%b h=%b v=%b want all 0",
                     load_pc, load_latch, flush, halted, valid);
        end
        checks++;
        if ({stall_cnt, flush_cnt, retire_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d/%0d want 0", stall_cnt, flush_cnt, retire_cnt);
        end
        rst_n = 1;
    endtask

    task test_fill();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== fill_exp[i]) begin
                errors++;
                $display("FAIL fill_%0d got %b want %b", i, valid, fill_exp[i]);
            end
            if (i < 3) step();
        end
    endtask

    task test_load_use();
        s0 = stall_cnt;
        ex_is_load = 1; ex_dest = 3'd1; id_src1 = 3'd1; id_use_src1 = 1;
        chk_cycle();
        checks++;
        if (load_latch[0] !== 1'b0) begin
            errors++;
            $display("FAIL luse_hold got load_latch[0]=%b want 0", load_latch[0]);
        end
        adv();
        checks++;
        if (valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL luse_bubble got valid[1]=%b want 0", valid[1]);
        end
        step();
        idle_in();
        checks++;
        if (valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL luse_single got valid[1]=%b want 1", valid[1]);
        end
        checks++;
        if (stall_cnt - s0 !== (PERF ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL luse_cnt got %0d want %0d", stall_cnt - s0, PERF ? 1 : 0);
        end
        step();
    endtask

    task test_dstall();
        s0 = stall_cnt;
        dmem_req = 1; dmem_resp = 0;
        for (int i = 0; i < 3; i++) begin
            chk_cycle();
            checks++;
            if ({load_pc, load_latch} !== 5'b01000) begin
                errors++;
                $display("FAIL dstall_hold_%0d got pc=%b ll=%b want pc=0 ll=1000", i, load_pc, load_latch);
            end
            adv();
            checks++;
            if (valid !== 4'b0111) begin
                errors++;
                $display("FAIL dstall_bubble_%0d got %b want 0111", i, valid);
            end
        end
        dmem_resp = 1;
        step();
        idle_in();
        checks++;
        if (stall_cnt - s0 !== (PERF ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL dstall_cnt got %0d want %0d", stall_cnt - s0, PERF ? 3 : 0);
        end
        step();
    endtask

    task test_flush();
        s0 = flush_cnt;
        br_taken = 1;
        chk_cycle();
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL flush_pulse got %b want 1", flush);
        end
        adv();
        br_taken = 0;
        checks++;
        if (valid !== 4'b0000) begin
            errors++;
            $display("FAIL flush_clear got %b want 0000", valid);
        end
        checks++;
        if (flush_cnt - s0 !== (PERF ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL flush_cnt got %0d want %0d", flush_cnt - s0, PERF ? 1 : 0);
        end
    endtask

    task test_flush_vs_dstall();
        refill();
        dmem_req = 1; dmem_resp = 0; br_taken = 1;
        chk_cycle();
        checks++;
        if ({load_pc, flush, load_latch} !== 6'b111111) begin
            errors++;
            $display("FAIL flush_wins got pc=%b fl=%b ll=%b want 1 1 1111", load_pc, flush, load_latch);
        end
        adv();
        idle_in();
        checks++;
        if (valid !== 4'b0000) begin
            errors++;
            $display("FAIL flush_wins_clear got %b want 0000", valid);
        end
    endtask

    task test_halt_resume();
        refill();
        halt_req = 1;
        step();
        halt_req = 0;
        repeat (4) step();
        checks++;
        if ({valid, halted} !== 5'b00000) begin
            errors++;
            $display("FAIL drain_empty got v=%b h=%b want 0000 0", valid, halted);
        end
        step();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_enter got %b want 1", halted);
        end
        repeat (2) step();
        resume = 1;
        step();
        resume = 0;
        chk_cycle();
        checks++;
        if (load_pc !== 1'b1) begin
            errors++;
            $display("FAIL resume_fetch got %b want 1", load_pc);
        end
        adv();
    endtask

    task test_halt_with_branch();
        refill();
        halt_req = 1; br_taken = 1;
        chk_cycle();
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL halt_br_flush got %b want 1", flush);
        end
        adv();
        idle_in();
        step();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_br_halted got %b want 1", halted);
        end
        resume = 1;
        step();
        resume = 0;
    endtask

    task test_reset_mid_drain();
        refill();
        halt_req = 1;
        step();
        halt_req = 0;
        dmem_req = 1; dmem_resp = 0;
        step();
        rst_n = 0;
        #1;
        checks++;
        if ({load_pc, load_latch, flush, halted, valid} !== 11'd0 ||
            {stall_cnt, flush_cnt, retire_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL reset_mid_drain got pc=%b ll=%b fl=%b h=%b v=%b cnt=%0d/%0d/%0d want all 0",
                     load_pc, load_latch, flush, halted, valid, stall_cnt, flush_cnt, retire_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (3) step();
        idle_in();
    endtask

    task test_random();
        for (int i = 0; i < 400; i++) begin
            imem_resp   = ($urandom_range(0, 3) != 0);
            dmem_req    = $urandom_range(0, 1) == 1;
            dmem_resp   = ($urandom_range(0, 2) == 0);
            id_src1     = 3'($urandom_range(0, 3));
            id_src2     = 3'($urandom_range(0, 3));
            ex_dest     = 3'($urandom_range(0, 3));
            id_use_src1 = $urandom_range(0, 1) == 1;
            id_use_src2 = $urandom_range(0, 1) == 1;
            ex_is_load  = $urandom_range(0, 1) == 1;
            br_taken    = ($urandom_range(0, 9) == 0);
            halt_req    = ($urandom_range(0, 39) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            step();
        end
        idle_in();
    endtask

    initial begin
        fill_exp[0] = 4'b0001; fill_exp[1] = 4'b0011;
        fill_exp[2] = 4'b0111; fill_exp[3] = 4'b1111;
        test_reset();
        test_fill();
        test_load_use();
        test_dstall();
        test_flush();
        test_flush_vs_dstall();
        test_halt_resume();
        test_halt_with_branch();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
